// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory: controller states and the
// RISC-V NOP encoding used as the power-up fill pattern.
package imem_pkg;

  // The controller first fills the array, then serves fetches.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : imem_pkg

// File: rtl/imem_array.sv
// Word-addressed storage with one write port and one registered read port.
// A read and a write to the same word in one cycle return the old contents.
module imem_array #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; contents are never reset, the controller refills them instead.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; holds its value between reads so a stalled response stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule : imem_array

// File: rtl/instr_mem_sync.sv
// Instruction memory with a valid/ready fetch channel, a program-load port and
// a self-fill to NOP after every reset.
module instr_mem_sync
  import imem_pkg::*;
#(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] FILL_VAL = DATA_W'(NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              init_busy
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int DEPTH  = 1 << WORD_W;

  state_t            state;
  state_t            state_next;
  logic [WORD_W-1:0] fill_cnt;
  logic              rsp_valid_q;
  logic              rsp_fault_q;
  logic              accept;
  logic              wr_en;
  logic [WORD_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              ld_addr_unused;

  // Loads are word-aligned; the byte-offset bits carry no information.
  assign ld_addr_unused = ^ld_addr[1:0];

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Fill counter walks every word once while initialising.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (state == ST_INIT) begin
      fill_cnt <= fill_cnt + WORD_W'(1);
    end
  end

  // Next state, write-port steering and channel handshake outputs.
  always_comb begin
    state_next = state;
    init_busy  = 1'b0;
    req_ready  = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = ld_addr[ADDR_W-1:2];
    wr_data    = ld_data;
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = fill_cnt;
        wr_data   = FILL_VAL;
        if (fill_cnt == '1) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        req_ready = !rsp_valid_q || rsp_ready || flush;
        wr_en     = ld_en;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  assign accept = req_valid && req_ready;

  // Response valid/fault tracking; an accept always wins over a drain or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_fault_q <= |req_addr[1:0];
    end else if (rsp_ready || flush) begin
      rsp_valid_q <= 1'b0;
    end
  end

  imem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (accept),
    .rd_addr (req_addr[ADDR_W-1:2]),
    .rd_data (rd_data)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_data  = rsp_fault_q ? FILL_VAL : rd_data;

endmodule : instr_mem_sync

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync: fill timing, fetch/stall/flush/load
// vectors and reset in the middle of both fill and normal operation.
module tb_instr_mem_sync;

  typedef struct {
    logic        req_valid;
    logic [8:0]  req_addr;
    logic        rsp_ready;
    logic        flush;
    logic        ld_en;
    logic [8:0]  ld_addr;
    logic [31:0] ld_data;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_fault;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [8:0]  req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        flush;
  logic        ld_en;
  logic [8:0]  ld_addr;
  logic [31:0] ld_data;
  logic        init_busy;

  int total = 0;
  int bad   = 0;

  vec_t vecs [21];

  instr_mem_sync dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: act=timeout req=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    req_valid = v.req_valid;
    req_addr  = v.req_addr;
    rsp_ready = v.rsp_ready;
    flush     = v.flush;
    ld_en     = v.ld_en;
    ld_addr   = v.ld_addr;
    ld_data   = v.ld_data;
    #1;
    checkOutput($sformatf("vec%0d.req_ready", idx), 32'(req_ready), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d.rsp_valid", idx), 32'(rsp_valid), 32'(v.exp_valid));
    if (v.exp_valid) begin
      checkOutput($sformatf("vec%0d.rsp_data", idx), rsp_data, v.exp_data);
      checkOutput($sformatf("vec%0d.rsp_fault", idx), 32'(rsp_fault), 32'(v.exp_fault));
    end
  endtask

  task automatic idleInputs();
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    flush     = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
  endtask

  // One reset edge, then reset-state checks.
  task automatic doReset(input string tag);
    rst       = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput({tag, ".rst_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, ".rst_data"}, rsp_data, 32'd0);
    checkOutput({tag, ".rst_fault"}, 32'(rsp_fault), 32'd0);
    checkOutput({tag, ".rst_busy"}, 32'(init_busy), 32'd1);
    checkOutput({tag, ".rst_ready"}, 32'(req_ready), 32'd0);
  endtask

  // Count busy cycles from the reset edge; a request and a load are held
  // the whole time and must both be ignored.
  task automatic waitFill(input string tag);
    int n = 0;
    req_valid = 1'b1;
    req_addr  = 9'h004;
    ld_en     = 1'b1;
    ld_addr   = 9'h000;
    ld_data   = 32'hDEAD_BEEF;
    while (init_busy && n < 400) begin
      n++;
      if (n == 64) begin
        checkOutput({tag, ".init_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, ".init_valid"}, 32'(rsp_valid), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    idleInputs();
    checkOutput({tag, ".fill_cycles"}, 32'(n), 32'd128);
    checkOutput({tag, ".busy_after"}, 32'(init_busy), 32'd0);
  endtask

  task automatic fetch(input string tag, input logic [8:0] addr, input logic [31:0] exp_data,
                       input logic exp_fault);
    req_valid = 1'b1;
    req_addr  = addr;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, ".data"}, rsp_data, exp_data);
    checkOutput({tag, ".fault"}, 32'(rsp_fault), 32'(exp_fault));
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [8:0] addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  initial begin
    // req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
    // exp_ready, exp_valid, exp_data, exp_fault
    vecs[0]  = '{1'b1, 9'h000, 1'b1, 1'b0, 1'b0, 9'h000, 32'h0,         1'b1, 1'b1, 32'h0000_0013, 1'b0};
    vecs[1]  = '{1'b1, 9'h1FC, 1'b1, 1'b0, 1'b0, 9'h000, 32'h0,         1'b1, 1'b1, 32'h0000_0013, 1'b0};
    vecs[2]  = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 9'h004, 32'h0010_0093, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 9'h008, 32'h0020_0113, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 9'h00E, 32'h0030_0193, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[5]  = '{1'b1, 9'h004, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         1'b1, 1'b1, 32'h0010_0093, 1'b0};
    vecs[6]  = '{1'b1, 9'h008, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         1'b0, 1'b1, 32'h0010_0093, 1'b0};
    vecs[7]  = '{1'b1, 9'h008, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         1'b0, 1'b1, 32'h0010_0093, 1'b0};
    vecs[8]  = '{1'b1, 9'h008, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         1'b0, 1'b1, 32'h0010_0093, 1'b0};
    vecs[9]  = '{1'b1, 9'h008, 1'b1, 1'b0, 1'b0, 9'h000, 32'h0,         1'b1, 1'b1, 32'h0020_0113, 1'b0};
    vecs[10] = '{1'b1, 9'h006, 1'b1, 1'b0, 1'b0, 9'h000, 32'h0,         1'b1, 1'b1, 32'h0000_0013, 1'b1};
    vecs[11] = '{1'b1, 9'h00C, 1'b1, 1'b0, 1'b0, 9'h000, 32'h0,         1'b1, 1'b1, 32'h0030_0193, 1'b0};
    vecs[12] = '{1'b1, 9'h1FC, 1'b1, 1'b0, 1'b0, 9'h000, 32'h0,         1'b1, 1'b1, 32'h0000_0013, 1'b0};
    vecs[13] = '{1'b1, 9'h004, 1'b1, 1'b0, 1'b0, 9'h000, 32'h0,         1'b1, 1'b1, 32'h0010_0093, 1'b0};
    vecs[14] = '{1'b1, 9'h010, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         1'b0, 1'b1, 32'h0010_0093, 1'b0};
    vecs[15] = '{1'b1, 9'h010, 1'b0, 1'b1, 1'b0, 9'h000, 32'h0,         1'b1, 1'b1, 32'h0000_0013, 1'b0};
    vecs[16] = '{1'b1, 9'h010, 1'b1, 1'b0, 1'b1, 9'h010, 32'h0032_0433, 1'b1, 1'b1, 32'h0000_0013, 1'b0};
    vecs[17] = '{1'b1, 9'h010, 1'b1, 1'b0, 1'b0, 9'h000, 32'h0,         1'b1, 1'b1, 32'h0032_0433, 1'b0};
    vecs[18] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 9'h000, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0};
    vecs[19] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0};
    vecs[20] = '{1'b1, 9'h004, 1'b0, 1'b0, 1'b0, 9'h000, 32'h0,         1'b1, 1'b1, 32'h0010_0093, 1'b0};

    idleInputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] power-on reset and fill");
    doReset("por");
    waitFill("por");

    $display("[TB] table vectors");
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i], i);
    end

    $display("[TB] reset during run with a stalled response");
    idleInputs();
    doReset("run_rst");
    waitFill("run_rst");
    fetch("run_rst.word1", 9'h004, 32'h0000_0013, 1'b0);
    fetch("run_rst.word4", 9'h010, 32'h0000_0013, 1'b0);

    $display("[TB] reset during fill");
    load(9'h004, 32'h0010_0093);
    fetch("reload.word1", 9'h004, 32'h0010_0093, 1'b0);
    doReset("fill_rst_a");
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
    end
    #1;
    checkOutput("fill50.busy", 32'(init_busy), 32'd1);
    doReset("fill_rst_b");
    waitFill("fill_rst_b");
    fetch("fill_rst.word1", 9'h004, 32'h0000_0013, 1'b0);
    fetch("fill_rst.word0", 9'h000, 32'h0000_0013, 1'b0);

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_instr_mem_sync

// File: doc/instr_mem_sync.md
INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning byte-address width; depth = 2**(ADDR_W-2) words.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction width.
REQ-003 SHALL have parameter FILL_VAL, default 32'h00000013 (addi x0,x0,0 NOP), meaning post-reset contents of every word.
REQ-004 SHALL have port clk, input, 1, meaning single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_addr (in, ADDR_W), meaning fetch-request channel; req_addr is the PC byte address.
REQ-007 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_data (out, DATA_W), rsp_fault (out, 1), meaning fetch-response channel.
REQ-008 SHALL have port flush, input, 1, meaning branch redirect that discards the held response.
REQ-009 SHALL have ports ld_en (in, 1), ld_addr (in, ADDR_W), ld_data (in, DATA_W), meaning program-load write port; ld_addr[1:0] ignored.
REQ-010 SHALL have port init_busy, output, 1, meaning array fill in progress.

Function
REQ-011 SHALL implement FSM {INIT, RUN}; reset enters INIT with fill counter 0.
REQ-012 INIT SHALL write FILL_VAL to word[cnt] each cycle, cnt+1; after word 2**(ADDR_W-2)-1 is written, next state RUN (fill takes exactly 2**(ADDR_W-2) cycles).
REQ-013 In INIT: init_busy=1, req_ready=0, rsp_valid=0; ld_en ignored.
REQ-014 In RUN: req_ready = !rsp_valid || rsp_ready || flush.
REQ-015 A request SHALL be accepted when req_valid && req_ready; rsp_valid asserts the following cycle (latency 1) with rsp_data = word[req_addr[ADDR_W-1:2]].
REQ-016 rsp_data, rsp_fault SHALL hold stable while rsp_valid && !rsp_ready.
REQ-017 rsp_valid SHALL clear after rsp_ready handshake with no new accept, or on flush with no same-cycle accept.
REQ-018 flush and accept in the same cycle: old response dropped, new request's response valid next cycle.
REQ-019 req_addr[1:0] != 0 SHALL produce rsp_fault=1 and rsp_data=FILL_VAL; otherwise rsp_fault=0.
REQ-020 ld_en in RUN SHALL write ld_data to word[ld_addr[ADDR_W-1:2]] at clock edge.
REQ-021 Same-cycle load and accept to same word SHALL return old data (read-before-write).
REQ-022 Back-to-back accepts with rsp_ready held 1 SHALL sustain one response per cycle.

Reset
REQ-023 On rst: state=INIT, cnt=0, rsp_valid=0, rsp_data=0, rsp_fault=0, init_busy=1, req_ready=0.
REQ-024 rst asserted mid-INIT or mid-RUN SHALL restart the full fill; pending response discarded; prior loaded program lost.

Structure
REQ-025 Package imem_pkg SHALL hold the FSM state enum and the NOP constant 32'h00000013.
REQ-026 Storage SHALL be one sub-module imem_array: 1 write port, 1 synchronous read port, read-before-write, DEPTH/DATA_W parameters.
REQ-027 Total RTL SHALL be 120-400 lines; no combinational read path from req_addr to rsp_data.

Verification
REQ-028 Reset, ADDR_W=9: init_busy=1 for exactly 128 cycles, then 0; fetch 0x1FC -> rsp_data=0x00000013, rsp_fault=0.
REQ-029 Load word 1 = 0x00100093 via ld_en, fetch 0x004 -> next cycle rsp_valid=1, rsp_data=0x00100093.
REQ-030 Hold rsp_ready=0 three cycles after fetch of 0x004 -> rsp_data stable, req_ready=0; then rsp_ready=1 with new req 0x008 -> accepted same cycle.
REQ-031 Fetch 0x006 -> rsp_fault=1, rsp_data=0x00000013.
REQ-032 Stalled response plus flush with req 0x010 same cycle -> stalled data dropped, next rsp_data=word[4]; load 0x00320433 to word 4 same cycle as fetch 0x010 -> old value returned, refetch returns 0x00320433.
REQ-033 rst pulsed at fill cycle 50 -> init_busy remains 1 for 128 further cycles; prior loads read back 0x00000013.
